// File: rtl/mac_pkg.sv
// Shared constants for the FP16 MAC accumulate stage: default widths and latency,
// and the bit positions of the per-beat sideband flags.
package mac_pkg;

  localparam int unsigned MulLatDefault = 4;
  localparam int unsigned AccWDefault   = 24;
  localparam int unsigned CntWDefault   = 8;
  localparam int unsigned ProdW         = 16;

  // Sideband flags travel as one vector through the delay line.
  localparam int unsigned SbValid = 0;
  localparam int unsigned SbFirst = 1;
  localparam int unsigned SbLast  = 2;
  localparam int unsigned SbWidth = 3;

endpackage

// File: rtl/sideband_delay.sv
// Enabled shift register that carries per-beat flags alongside the multiplier
// pipeline. It has a synchronous reset and holds its contents when en_i is low.
module sideband_delay #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;

  assign stage_d[0] = en_i ? d_i : stage_q[0];

  for (genvar g = 1; g < DEPTH; g++) begin : g_shift
    assign stage_d[g] = en_i ? stage_q[g-1] : stage_q[g];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/mac_accumulator.sv
// Accumulates aligned multiplier products per vector into a saturating accumulator,
// emits one result per vector over valid/ready, and owns the MAC pipeline freeze.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int unsigned MUL_LAT = MulLatDefault,
  parameter int unsigned ACC_W   = AccWDefault,
  parameter int unsigned CNT_W   = CntWDefault
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic             in_first,
  input  logic             in_last,
  input  logic [ProdW-1:0] prod_in,
  output logic             pipe_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat
);

  logic [SbWidth-1:0] sb_in, sb_al;
  logic               d_valid, d_first, d_last, beat;

  logic [ACC_W-1:0]   acc_q, acc_d, acc_nx, acc_base;
  logic [ACC_W:0]     sum, prod_ext;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_nx;
  logic               sat_q, sat_d, sat_nx;

  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_data_q, out_data_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               out_sat_q, out_sat_d;

  // A pending, unaccepted result freezes the multiplier, the delay line and the accumulator.
  assign pipe_en = en & ~(out_valid_q & ~out_ready);

  always_comb begin
    sb_in          = '0;
    sb_in[SbValid] = in_valid;
    sb_in[SbFirst] = in_valid & in_first;
    sb_in[SbLast]  = in_valid & in_last;
  end

  sideband_delay #(
    .WIDTH (SbWidth),
    .DEPTH (MUL_LAT)
  ) u_sideband_delay (
    .clk_i (sys_clk),
    .rst_i (rst),
    .en_i  (pipe_en),
    .d_i   (sb_in),
    .q_o   (sb_al)
  );

  assign d_valid  = sb_al[SbValid];
  assign d_first  = sb_al[SbFirst];
  assign d_last   = sb_al[SbLast];
  assign beat     = pipe_en & d_valid;
  assign prod_ext = {{(ACC_W + 1 - ProdW){1'b0}}, prod_in};

  always_comb begin
    acc_base = d_first ? '0 : acc_q;
    sum      = {1'b0, acc_base} + prod_ext;
    acc_nx   = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
    sat_nx   = (~d_first & sat_q) | sum[ACC_W];
    if (d_first) begin
      cnt_nx = CNT_W'(1);
    end else if (&cnt_q) begin
      cnt_nx = cnt_q;
    end else begin
      cnt_nx = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q & ~out_ready;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_sat_d   = out_sat_q;
    if (beat) begin
      if (d_last) begin
        // Can coincide with the handshake of the previous result; pipe_en is high then.
        out_valid_d = 1'b1;
        out_data_d  = acc_nx;
        out_count_d = cnt_nx;
        out_sat_d   = sat_nx;
        acc_d       = '0;
        cnt_d       = '0;
        sat_d       = 1'b0;
      end else begin
        acc_d = acc_nx;
        cnt_d = cnt_nx;
        sat_d = sat_nx;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: two instances (24-bit and 17-bit accumulators) share one
// multiplier model and stimulus; results are checked against a per-vector sum model.
module tb_mac_accumulator;
  import mac_pkg::*;

  localparam int unsigned L     = MulLatDefault;
  localparam int unsigned AccW0 = 24;
  localparam int unsigned AccW1 = 17;
  localparam int unsigned CntW  = 8;
  localparam longint unsigned Max0   = (64'd1 << AccW0) - 1;
  localparam longint unsigned Max1   = (64'd1 << AccW1) - 1;
  localparam longint unsigned CntMax = (64'd1 << CntW) - 1;

  typedef struct {
    longint unsigned d0;
    longint unsigned d1;
    longint unsigned cnt;
    bit              s0;
    bit              s1;
  } exp_t;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic             rst, en, in_valid, in_first, in_last, out_ready;
  logic [7:0]       op_a, op_b;
  logic [15:0]      mul_q [L];
  logic [15:0]      prod_in;
  logic             pipe_en0, pipe_en1, out_valid0, out_valid1, out_sat0, out_sat1;
  logic [AccW0-1:0] out_data0;
  logic [AccW1-1:0] out_data1;
  logic [CntW-1:0]  out_count0, out_count1;

  int              n_asserts = 0;
  int              n_fail = 0;
  int              cyc = 0;
  bit              checking = 1'b0;
  bit              rand_ready = 1'b0;
  exp_t            exp_q[$];
  int              hs_t[$];
  longint unsigned m_sum = 0;
  longint unsigned m_n = 0;

  mac_accumulator #(.MUL_LAT(L), .ACC_W(AccW0), .CNT_W(CntW)) u_dut0 (
    .sys_clk(sys_clk), .rst(rst), .en(en), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .prod_in(prod_in), .pipe_en(pipe_en0), .out_valid(out_valid0),
    .out_ready(out_ready), .out_data(out_data0), .out_count(out_count0), .out_sat(out_sat0)
  );

  mac_accumulator #(.MUL_LAT(L), .ACC_W(AccW1), .CNT_W(CntW)) u_dut1 (
    .sys_clk(sys_clk), .rst(rst), .en(en), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .prod_in(prod_in), .pipe_en(pipe_en1), .out_valid(out_valid1),
    .out_ready(out_ready), .out_data(out_data1), .out_count(out_count1), .out_sat(out_sat1)
  );

  // Pipelined 8x8 multiplier stand-in, frozen by pipe_en like the real one.
  always @(posedge sys_clk) begin
    if (pipe_en0) begin
      mul_q[0] <= 16'(op_a) * 16'(op_b);
      for (int i = 1; i < L; i++) mul_q[i] <= mul_q[i-1];
    end
  end
  assign prod_in = mul_q[L-1];

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_asserts++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic void model_beat(input bit f, input bit l, input longint unsigned p);
    exp_t e;
    if (f) begin
      m_sum = 0;
      m_n   = 0;
    end
    m_sum += p;
    m_n++;
    if (l) begin
      e.d0  = (m_sum > Max0) ? Max0 : m_sum;
      e.s0  = (m_sum > Max0);
      e.d1  = (m_sum > Max1) ? Max1 : m_sum;
      e.s1  = (m_sum > Max1);
      e.cnt = (m_n > CntMax) ? CntMax : m_n;
      exp_q.push_back(e);
      m_sum = 0;
      m_n   = 0;
    end
  endfunction

  function automatic logic [7:0] rnd_op();
    return ($urandom_range(0, 3) == 0) ? 8'hff : 8'($urandom);
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Holds the beat until an enabled edge captures it.
  task automatic send(input bit v, input bit f, input bit l, input logic [7:0] aa,
                      input logic [7:0] bb);
    bit took;
    took     = 1'b0;
    en       = 1'b1;
    in_valid = v;
    in_first = f;
    in_last  = l;
    op_a     = aa;
    op_b     = bb;
    for (int g = 0; g < 200 && !took; g++) begin
      @(negedge sys_clk);
      took = pipe_en0;
      tick();
    end
    check("beat_accepted", took, 1'b1);
    if (took && v) model_beat(f, l, 16'(aa) * 16'(bb));
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic bubble();
    en       = 1'b0;
    in_valid = 1'($urandom);
    in_first = 1'($urandom);
    in_last  = 1'($urandom);
    op_a     = 8'($urandom);
    op_b     = 8'($urandom);
    tick();
    en       = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g         = 0;
    in_valid  = 1'b0;
    en        = 1'b1;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid0 === 1'b1) && g < 300) begin
      tick();
      g++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic wait_valid();
    bit seen;
    seen = 1'b0;
    for (int g = 0; g < 100 && !seen; g++) begin
      @(negedge sys_clk);
      seen = out_valid0;
      if (!seen) tick();
    end
    check("wait_valid", seen, 1'b1);
    tick();
  endtask

  // Called right after the last beat was captured; out_ready must be 1.
  task automatic expect_latency(input bit toggle);
    int edges;
    bit pe;
    bit done;
    edges    = 1;  // capture edge of the last beat already counted
    done     = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      en = toggle ? c[0] : 1'b1;
      @(negedge sys_clk);
      pe = pipe_en0;
      check("latency", out_valid0, edges == 5);
      if (edges == 5) done = 1'b1;
      tick();
      if (pe) edges++;
    end
    check("latency_reached", done, 1'b1);
    en = 1'b1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    m_sum = 0;
    m_n   = 0;
    exp_q.delete();
    tick();
    rst = 1'b0;
  endtask

  // Scoreboard and protocol checks, sampled on the falling edge.
  initial begin
    bit               prev_stall;
    logic [AccW0-1:0] prev_data;
    exp_t             e;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge sys_clk);
      if (rst || !checking) begin
        prev_stall = 1'b0;
      end else begin
        check("pipe_en", pipe_en0, en & ~(out_valid0 & ~out_ready));
        check("pipe_en_w17", pipe_en1, pipe_en0);
        check("out_valid_w17", out_valid1, out_valid0);
        if (prev_stall) check("stall_hold", out_data0, prev_data);
        if (out_valid0 && out_ready) begin
          check("result_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("out_data", out_data0, e.d0);
            check("out_count", out_count0, e.cnt);
            check("out_sat", out_sat0, e.s0);
            check("out_data_w17", out_data1, e.d1);
            check("out_count_w17", out_count1, e.cnt);
            check("out_sat_w17", out_sat1, e.s1);
          end
          hs_t.push_back(cyc);
        end
        prev_stall = out_valid0 & ~out_ready;
        prev_data  = out_data0;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned len;
    bit          skip_first;
    int unsigned r;
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    op_a = '0; op_b = '0; out_ready = 1'b0;

    // Reset state; pipe_en follows en while reset holds.
    tick();
    @(negedge sys_clk);
    check("rst_pipe_en_hi", pipe_en0, 1'b1);
    check("rst_out_valid", out_valid0, 1'b0);
    check("rst_out_data", out_data0, 0);
    check("rst_out_count", out_count0, 0);
    check("rst_out_sat", out_sat0, 1'b0);
    tick();
    en = 1'b0;
    @(negedge sys_clk);
    check("rst_pipe_en_lo", pipe_en0, 1'b0);
    tick();
    rst = 1'b0; en = 1'b1; out_ready = 1'b1; checking = 1'b1;

    // Single beat 3x5 with exact latency.
    send(1, 1, 1, 8'd3, 8'd5);
    expect_latency(1'b0);
    drain();

    // Back-to-back vectors: 140 then 1, results on consecutive cycles.
    send(1, 1, 0, 8'd2, 8'd3);
    send(1, 0, 0, 8'd4, 8'd5);
    send(1, 0, 0, 8'd6, 8'd7);
    send(1, 0, 1, 8'd8, 8'd9);
    send(1, 1, 1, 8'd1, 8'd1);
    drain();
    check("no_bubble", hs_t[hs_t.size()-1] - hs_t[hs_t.size()-2], 1);

    // Saturation on the 17-bit instance, then a clean vector.
    send(1, 1, 0, 8'd255, 8'd255);
    send(1, 0, 0, 8'd255, 8'd255);
    send(1, 0, 1, 8'd255, 8'd255);
    send(1, 1, 1, 8'd1, 8'd2);
    drain();

    // Backpressure for 6 cycles with a second vector in flight.
    out_ready = 1'b0;
    send(1, 1, 1, 8'd7, 8'd9);
    send(1, 1, 0, 8'd2, 8'd2);
    send(1, 0, 0, 8'd3, 8'd3);
    send(1, 0, 1, 8'd4, 8'd4);
    wait_valid();
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk);
      check("stall_pipe_en", pipe_en0, 1'b0);
      check("stall_data", out_data0, 63);
      tick();
    end
    drain();

    // Gap-free run, then the same beats with en bubbles and in_valid gaps.
    send(1, 1, 0, 8'd11, 8'd12);
    send(1, 0, 0, 8'd13, 8'd14);
    send(1, 0, 0, 8'd15, 8'd16);
    send(1, 0, 1, 8'd17, 8'd18);
    drain();
    send(1, 1, 0, 8'd11, 8'd12);
    bubble();
    send(0, 1, 1, 8'd99, 8'd99);
    bubble();
    send(1, 0, 0, 8'd13, 8'd14);
    bubble();
    send(1, 0, 0, 8'd15, 8'd16);
    send(0, 0, 1, 8'd77, 8'd77);
    bubble();
    send(1, 0, 1, 8'd17, 8'd18);
    expect_latency(1'b1);
    drain();

    // Reset mid-vector, then a fresh vector and a first-less beat.
    send(1, 1, 0, 8'd9, 8'd9);
    send(1, 0, 0, 8'd8, 8'd8);
    apply_reset();
    @(negedge sys_clk);
    check("abort_out_valid", out_valid0, 1'b0);
    tick();
    send(1, 1, 1, 8'd10, 8'd10);
    send(1, 0, 1, 8'd2, 8'd3);
    drain();

    // Reset while a result is pending and beats are in flight.
    out_ready = 1'b0;
    send(1, 1, 1, 8'd5, 8'd5);
    send(1, 1, 0, 8'd6, 8'd6);
    wait_valid();
    apply_reset();
    out_ready = 1'b1;
    @(negedge sys_clk);
    check("abort_pending", out_valid0, 1'b0);
    tick();
    send(1, 1, 1, 8'd10, 8'd10);
    drain();

    // Beat counter saturates at its maximum.
    for (int i = 0; i < 300; i++) send(1, i == 0, i == 299, 8'd1, 8'd1);
    drain();

    // Randomized vectors, bubbles, gaps and backpressure.
    rand_ready = 1'b1;
    for (int v = 0; v < 120; v++) begin
      len        = $urandom_range(1, 6);
      skip_first = ($urandom_range(0, 7) == 0);
      for (int unsigned i = 0; i < len; i++) begin
        r = $urandom_range(0, 5);
        if (r == 0) bubble();
        if (r == 1) send(1'b0, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
        send(1'b1, (i == 0) && !skip_first, i == len - 1, rnd_op(), rnd_op());
      end
    end
    rand_ready = 1'b0;
    drain();
    check("final_out_valid", out_valid0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Downstream consumer of the 8x8 pipelined unsigned mantissa multiplier in the FP16 MAC datapath. It carries per-operand sideband flags (valid/first/last) through a delay line matched to the multiplier latency and accumulates the aligned 16-bit products into a wide unsigned accumulator. It emits one saturated result per vector over a valid/ready output. It also owns the pipeline freeze, producing the enable that drives the multiplier and itself.

## Interface

Parameters:
- MUL_LAT, 4: multiplier latency in enabled cycles (operand sample to product valid).
- ACC_W, 24: accumulator/result width, >= 16.
- CNT_W, 8: beat-counter width.

Ports:
- sys_clk  input  1  single clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset; priority over every other input.
- en  input  1  upstream advance request.
- in_valid  input  1  operand beat valid, presented with the multiplier's a_in/b_in.
- in_first  input  1  first beat of a vector; qualified by in_valid.
- in_last  input  1  last beat of a vector; qualified by in_valid.
- prod_in  input  16  multiplier c_out.
- pipe_en  output  1  = en & ~(out_valid & ~out_ready); drives the multiplier en and all internal state.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_data  output  ACC_W  accumulated result.
- out_count  output  CNT_W  beats in the vector, saturating at 2^CNT_W-1.
- out_sat  output  1  accumulator saturated at some point during the vector.

## Operation

- Sideband delay: {in_valid,in_first,in_last} shift through MUL_LAT registers, advancing only when pipe_en=1. The tail is aligned with prod_in. Flags are forced 0 when in_valid=0.
- Aligned beat consumed when pipe_en=1 and d_valid=1:
  - d_first: acc_next = prod, cnt_next = 1, sat_next = 0.
  - otherwise: acc_next = acc + prod, cnt_next = cnt + 1 (saturating), sat sticky.
  - Sum computed at ACC_W+1 bits. If the carry is set, clamp to 2^ACC_W-1 and set sat.
  - d_last: load out_data/out_count/out_sat from the next values, set out_valid, and clear acc/cnt/sat to 0.
  - d_first & d_last on the same beat gives a single-beat result equal to prod.
- A valid beat with no preceding first accumulates onto the current acc, which is 0 after reset or after a last.
- Non-valid aligned beats leave acc untouched.
- Output handshake: out_valid clears on out_valid & out_ready. While out_valid & ~out_ready, pipe_en=0, which freezes the multiplier, the delay line and acc, so no beat is lost. A new last cannot complete while a result is pending.
- Same-cycle completion: out_valid & out_ready together with a consumed d_last loads the new result with out_valid staying 1. This is legal because pipe_en=1 then.
- pipe_en is combinational from en and out_ready.

## Timing

- Reset values: out_valid=0, out_data=0, out_count=0, out_sat=0, acc=0, cnt=0, delay line=0. pipe_en = en during reset.
- Latency: operands plus flags sampled at enabled edge k yield product and aligned flags after edge k+MUL_LAT. A last beat sets out_valid after edge k+MUL_LAT+1. In total, 5 enabled edges from in_last to out_valid at the default.
- Enabled-edge counting: edges with pipe_en=0 do not count toward latency.
- Throughput: one beat per enabled cycle, one result per vector.
- Reset mid-vector or mid-handshake: the partial accumulation and any pending result are discarded. In-flight sideband is cleared, so products still in the multiplier are ignored.

## Structure

- Shared package/header `mac_pkg`: MUL_LAT default, ACC_W/CNT_W defaults, and the sideband field indices (VALID, FIRST, LAST).
- Sub-module `sideband_delay` (parameters WIDTH, DEPTH): enabled shift register with synchronous reset, instantiated with WIDTH=3, DEPTH=MUL_LAT.
- Accumulator, saturation, counter and output register live in the top.

## Test plan

- Single beat, a=3, b=5, first=last=1, out_ready=1 -> 5 cycles later out_data=15, out_count=1, out_sat=0, out_valid high for 1 cycle.
- Back-to-back vector (2,3),(4,5),(6,7),(8,9), then a second vector (1,1) immediately -> results 140 (count 4), then 1 (count 1), with no bubbles.
- ACC_W=17, three beats of 255x255 -> out_data=131071, out_sat=1, out_count=3. The next vector has out_sat=0.
- Hold out_ready=0 for 6 cycles with a second vector in flight:
  - pipe_en=0 throughout and out_data stable.
  - After release, the second result is correct with no lost or duplicated beat.
- en=0 bubbles every other cycle plus in_valid=0 gaps inside a vector of 4 beats -> same sum as the gap-free run, with latency stretched by the bubble count.
- rst asserted mid-vector after 2 beats, then a fresh vector (10,10) -> out_data=100, out_count=1, and no result from the aborted vector.
